// File: rtl/five_bit_adder.sv
// Registered 5-bit ripple-carry adder: 1-cycle latency, accepts a new operand pair every cycle, no backpressure.
// Defining FIVE_BIT_ADDER_OVF_EN adds a registered two's-complement overflow output ovf.
module five_bit_adder #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cout,
`ifdef FIVE_BIT_ADDER_OVF_EN
  output logic [WIDTH-1:0] result,
  output logic             ovf
`else
  output logic [WIDTH-1:0] result
`endif
);

  // Returns {co, s} for one bit position.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [1:0]       fa;

  // Ripple chain; carry[0] is the tied-off carry-in.
  always_comb begin
    carry = '0;
    sum   = '0;
    fa    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fa         = full_add(a[i], b[i], carry[i]);
      sum[i]     = fa[0];
      carry[i+1] = fa[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      cout   <= 1'b0;
    end else begin
      result <= sum;
      cout   <= carry[WIDTH];
    end
  end

`ifdef FIVE_BIT_ADDER_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else begin
      ovf <= carry[WIDTH-1] ^ carry[WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_five_bit_adder.sv
// Directed self-checking bench for five_bit_adder; covers ovf when FIVE_BIT_ADDER_OVF_EN is defined.
module tb_five_bit_adder;

  logic       clk;
  logic       rst_n;
  logic [4:0] a;
  logic [4:0] b;
  logic       cout;
  logic [4:0] result;
`ifdef FIVE_BIT_ADDER_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  five_bit_adder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .cout   (cout),
`ifdef FIVE_BIT_ADDER_OVF_EN
    .result (result),
    .ovf    (ovf)
`else
    .result (result)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive operands just after an edge, then check {cout,result} one edge later.
  task automatic add_step(input string tag, input logic [4:0] x, input logic [4:0] y,
                          input logic [5:0] exp);
    a = x;
    b = y;
    @(posedge clk);
    #1;
    chk(tag, {2'b00, cout, result}, {2'b00, exp});
  endtask

  initial begin
    rst_n = 1'b1;
    a = 5'b00111;
    b = 5'b01011;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {2'b00, cout, result}, 8'h00);
`ifdef FIVE_BIT_ADDER_OVF_EN
    chk("rst_ovf", {7'b0, ovf}, 8'h00);
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", {2'b00, cout, result}, 8'h00);
    end

    // Release between edges; first edge registers current a+b.
    @(negedge clk);
    rst_n = 1'b1;
    add_step("rel_first", 5'b00100, 5'b11011, 6'b011111);

    add_step("seq0", 5'b00111, 5'b01011, 6'b010010);
    a = 5'b00101;
    b = 5'b00100;
    #1;
    chk("no_comb_path", {2'b00, cout, result}, 8'h12);
    add_step("seq1", 5'b00101, 5'b00100, 6'b001001);
    add_step("seq2", 5'b01100, 5'b00100, 6'b010000);

    add_step("wrap_one", 5'b11111, 5'b00001, 6'b100000);
    add_step("wrap_max", 5'b11111, 5'b11111, 6'b111110);
    add_step("zero", 5'b00000, 5'b00000, 6'b000000);
    add_step("mixed", 5'b10101, 5'b01110, 6'b100011);
    add_step("hold0", 5'b01001, 5'b00110, 6'b001111);
    add_step("hold1", 5'b01001, 5'b00110, 6'b001111);

    add_step("ovf_pos", 5'b01111, 5'b00001, 6'b010000);
`ifdef FIVE_BIT_ADDER_OVF_EN
    chk("ovf_pos_flag", {7'b0, ovf}, 8'h01);
`endif
    add_step("ovf_neg", 5'b10000, 5'b10000, 6'b100000);
`ifdef FIVE_BIT_ADDER_OVF_EN
    chk("ovf_neg_flag", {7'b0, ovf}, 8'h01);
`endif
    add_step("ovf_none", 5'b00010, 5'b00001, 6'b000011);
`ifdef FIVE_BIT_ADDER_OVF_EN
    chk("ovf_none_flag", {7'b0, ovf}, 8'h00);
`endif

    // Mid-operation reset between edges discards the pending sum.
    add_step("pre_rst", 5'b00111, 5'b01011, 6'b010010);
    a = 5'b11111;
    b = 5'b11111;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {2'b00, cout, result}, 8'h00);
    @(posedge clk);
    #1;
    chk("mid_rst_edge", {2'b00, cout, result}, 8'h00);
`ifdef FIVE_BIT_ADDER_OVF_EN
    chk("mid_rst_ovf", {7'b0, ovf}, 8'h00);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    add_step("post_rst", 5'b00001, 5'b00010, 6'b000011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/five_bit_adder.md
FIVE_BIT_ADDER -- requirements
Module: five_bit_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, operand/result width; only 5 is supported and the bench SHALL use the default.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port a, input, 5 bits: unsigned addend A.
REQ-005 The block SHALL have port b, input, 5 bits: unsigned addend B.
REQ-006 The block SHALL have port cout, output, 1 bit: carry out of bit 4.
REQ-007 The block SHALL have port result, output, 5 bits: low 5 bits of A+B.
REQ-008 With FIVE_BIT_ADDER_OVF_EN defined, the block SHALL have port ovf, output, 1 bit: two's-complement signed overflow; without the macro, ovf SHALL NOT exist.
REQ-009 Positional port order SHALL be clk, rst_n, a, b, cout, result, then ovf when present.

Function
REQ-010 The sum SHALL be computed as a ripple chain of five 1-bit full adders, with carry-in to bit 0 tied to 0.
REQ-011 Each full adder SHALL compute s = x^y^ci and co = (x&y)|(ci&(x^y)).
REQ-012 {cout,result} SHALL equal a+b as a 6-bit unsigned value; range 0..62.
REQ-013 result and cout SHALL be registered; the values sampled at rising edge N SHALL appear at outputs after edge N, with 1-cycle latency and no combinational input-to-output path.
REQ-014 A new operand pair SHALL be accepted every cycle, with full throughput and no handshake.
REQ-015 Wrap-around: 11111+00001 SHALL give result 00000, cout 1; 11111+11111 SHALL give result 11110, cout 1.
REQ-016 Zero operands SHALL give result 00000, cout 0.
REQ-017 ovf, when present, SHALL be registered with the same latency and SHALL equal the carry into bit 4 XOR the carry out of bit 4.
REQ-018 Outputs SHALL hold their last registered value while inputs are unchanged; X/Z on inputs need not be handled.

Reset
REQ-019 rst_n low SHALL immediately, without a clock, force result=00000, cout=0, and ovf=0 when present.
REQ-020 While rst_n is low, outputs SHALL stay at reset values regardless of a, b, or clk.
REQ-021 After rst_n deasserts, the first rising edge SHALL register the current a+b.
REQ-022 Reset asserted mid-operation SHALL discard the pending sum, with no partial update.

Configuration
REQ-023 Macro FIVE_BIT_ADDER_OVF_EN SHALL control the ovf port, its overflow logic, and its register.
REQ-024 Without FIVE_BIT_ADDER_OVF_EN, the block SHALL be the plain unsigned adder of REQ-010 to REQ-016 with an identical cout/result timing.

Verification
REQ-025 Hold rst_n=0 with a=00111, b=01011 and toggle clk -> result 00000, cout 0 throughout.
REQ-026 Release reset; a=00100, b=11011 -> after 1 edge, result 11111, cout 0.
REQ-027 Sequence (00111,01011), (00101,00100), (01100,00100) on consecutive edges -> results 10010, 01001, 10000, each with cout 0, each 1 cycle later.
REQ-028 a=11111, b=00001 -> result 00000, cout 1; a=11111, b=11111 -> result 11110, cout 1.
REQ-029 With macro: a=01111, b=00001 -> ovf 1; a=10000, b=10000 -> ovf 1, cout 1, result 00000; a=00010, b=00001 -> ovf 0.
REQ-030 Assert rst_n low between clock edges while result=10010 -> outputs go to 0 before the next edge.
